// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter unit.
// Ops, FSM states and the target alignment rule.
package pc_pkg;

  typedef enum logic [3:0] {
    PC_SEQ  = 4'd0,
    PC_JAL  = 4'd1,
    PC_JALR = 4'd2,
    PC_BEQ  = 4'd3,
    PC_BNE  = 4'd4,
    PC_BLT  = 4'd5,
    PC_BGE  = 4'd6,
    PC_BLTU = 4'd7,
    PC_BGEU = 4'd8
  } pc_op_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

  // 16-bit alignment only needs bit 0 clear; 32-bit needs both low bits clear
  function automatic logic pc_aligned(
    input logic [1:0] lsb,
    input int         ialign
  );
    if (ialign == 16) return !lsb[0];
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control-side bundle of the pc unit.
// master drives ops and handshakes, slave is the pc unit.
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int XLEN = 32
);

  pc_op_t            op;
  logic              op_valid;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1;
  logic              zero;
  logic              negative;
  logic              ltu;
  logic              iready;
  logic              fault_clr;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   link;
  logic              taken;
  logic              stalled;
  logic              fault;

  modport master (
    output op, op_valid, imm, rs1,
    output zero, negative, ltu,
    output iready, fault_clr,
    input  pc, link, taken,
    input  stalled, fault
  );

  modport slave (
    input  op, op_valid, imm, rs1,
    input  zero, negative, ltu,
    input  iready, fault_clr,
    output pc, link, taken,
    output stalled, fault
  );

endinterface

// File: rtl/pc_target.sv
// Redirect evaluation: target address, taken and misaligned.
// Purely combinational, fed by the current pc and operands.
module pc_target
  import pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  pc_op_t          op,
  input  logic            op_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            zero,
  input  logic            negative,
  input  logic            ltu,
  output logic [XLEN-1:0] target,
  output logic            taken,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] CLR_LSB =
    {{(XLEN-1){1'b1}}, 1'b0};

  logic cond;

  // target address; JALR clears bit 0 of the sum
  always_comb begin
    target = pc + imm;
    if (op == PC_JALR)
      target = (rs1 + imm) & CLR_LSB;
  end

  // branch condition from the ALU flags
  always_comb begin
    cond = 1'b0;
    unique case (op)
      PC_JAL:  cond = 1'b1;
      PC_JALR: cond = 1'b1;
      PC_BEQ:  cond = zero;
      PC_BNE:  cond = !zero;
      PC_BLT:  cond = negative;
      PC_BGE:  cond = !negative;
      PC_BLTU: cond = ltu;
      PC_BGEU: cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign taken = op_valid && cond;

  assign misaligned =
    taken && !pc_aligned(target[1:0], IALIGN);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall and fault handling.
// A redirect seen while fetch is stalled is parked in pending.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              IALIGN    = 32
) (
  input  logic       clk,
  input  logic       RST,
  pc_unit_if.slave   bus
);

  pc_state_t       state_q;
  pc_state_t       state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pend_q;
  logic [XLEN-1:0] pend_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic            taken;
  logic            mis;

  pc_target #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target (
    .op         (bus.op),
    .op_valid   (bus.op_valid),
    .pc         (pc_q),
    .imm        (bus.imm),
    .rs1        (bus.rs1),
    .zero       (bus.zero),
    .negative   (bus.negative),
    .ltu        (bus.ltu),
    .target     (target),
    .taken      (taken),
    .misaligned (mis)
  );

  assign seq_pc = pc_q + XLEN'(4);

  // state register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  // next-state: stall parks a redirect, bad target traps
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mis)
          state_d = FAULT;
        else if (taken && !bus.iready)
          state_d = HOLD;
      end
      HOLD: begin
        if (bus.iready) state_d = RUN;
      end
      FAULT: begin
        if (bus.fault_clr) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // next pc and pending target for each state
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    unique case (state_q)
      RUN: begin
        if (!mis) begin
          if (bus.iready)
            pc_d = taken ? target : seq_pc;
          else if (taken)
            pend_d = target;
        end
      end
      HOLD: begin
        if (bus.iready) pc_d = pend_q;
      end
      FAULT: begin
        if (bus.fault_clr) pc_d = TRAP_VEC;
      end
      default: pc_d = pc_q;
    endcase
  end

  // pc and pending registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pc_q   <= RESET_VEC;
      pend_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.link    = seq_pc;
  assign bus.taken   = taken;
  assign bus.stalled = (state_q == HOLD);
  assign bus.fault   = (state_q == FAULT);

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage of the RISC-V core, the successor to the fixed 32-bit `pc`. It computes the next fetch address from the control-unit op, the sign-extended immediate, rs1 and the ALU flags. It holds the PC while instruction memory is not ready, and latches a taken redirect that resolves during a stall until fetch can accept it. It also detects misaligned jump/branch targets and parks in a fault state until the trap handler releases it.

## Interface
- `XLEN`, 32, address/data width
- `RESET_VEC`, 0, PC value after reset
- `TRAP_VEC`, 32'h100, PC loaded on `fault_clr`
- `IALIGN`, 32, 32 checks target[1:0]; 16 checks target[0] only
- `clk`  in  1  core clock, all state on rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `op`  in  pc_op_t  PC_SEQ, PC_JAL, PC_JALR, PC_BEQ, PC_BNE, PC_BLT, PC_BGE, PC_BLTU, PC_BGEU
- `op_valid`  in  1  `op`/operands valid this cycle
- `imm`  in  XLEN  sign-extended immediate
- `rs1`  in  XLEN  rs1 read data (JALR base)
- `zero`, `negative`, `ltu`  in  1 each  ALU flags for rs1-rs2: equal, signed-less, unsigned-less
- `iready`  in  1  instruction memory accepts a fetch address
- `fault_clr`  in  1  single-cycle release from FAULT
- `pc`  out  XLEN  current fetch address (registered)
- `link`  out  XLEN  `pc + 4`, combinational (JAL/JALR rd data)
- `taken`  out  1  combinational, taken redirect this cycle
- `stalled`  out  1  registered, high in HOLD
- `fault`  out  1  registered, high in FAULT

## Operation
- Reset: `pc`=RESET_VEC, state RUN, pending=0, `stalled`=0, `fault`=0.
- Target: JAL and branches use `pc + imm`. JALR uses `(rs1 + imm) & ~1`. All sums wrap modulo 2^XLEN.
- Taken: JAL/JALR always. BEQ `zero`, BNE `!zero`, BLT `negative`, BGE `!negative`, BLTU `ltu`, BGEU `!ltu`. PC_SEQ is never taken. `taken`=0 whenever `op_valid`=0.
- Misaligned: taken && target fails the IALIGN check.
- States:
  - RUN:
    - `iready`=1: `pc` loads target if taken and aligned, else `pc+4`.
    - `iready`=0, taken and aligned: pending loads target, go to HOLD.
    - `iready`=0, not taken: `pc` holds.
    - Taken and misaligned, regardless of `iready`: go to FAULT, `pc` holds.
  - HOLD: `op_valid` is ignored, since upstream is stalled. When `iready`=1, `pc` loads pending and the state returns to RUN. Otherwise hold.
  - FAULT: `pc` is frozen and all ops are ignored. `fault_clr` loads TRAP_VEC into `pc` and returns to RUN. `iready` is ignored for this transition.
- `fault_clr` outside FAULT has no effect.
- `RST` mid-operation discards pending and FAULT immediately, asynchronously.

## Timing
- Registered `pc`: a redirect decided in cycle N appears on `pc` after edge N (1-cycle latency). From HOLD, the redirect appears on the first edge with `iready`=1.
- `link` and `taken` are combinational from inputs in the same cycle. `stalled` and `fault` change on the edge that enters or leaves the state.
- A redirect and `iready` falling in the same cycle: the redirect is latched into pending, never lost.
- Wrap-around: `pc`=2^XLEN-4 with PC_SEQ gives 0.

## Structure
- Package `pc_pkg`: `pc_op_t` enum (4-bit), `pc_state_t` (RUN, HOLD, FAULT), and a function for the alignment check.
- Sub-module `pc_target`: combinational target, taken and misaligned evaluation.
- `pc_unit` holds the FSM, `pc` register and pending register.

## Test plan
- Reset: assert `RST` asynchronously mid-cycle with RESET_VEC=0 → `pc`=0, `stalled`=0, `fault`=0 immediately; release, then 3 PC_SEQ cycles with `iready`=1 → `pc` = 4, 8, 12.
- JAL/JALR: at `pc`=0x10 issue JAL `imm`=0x1234 → `pc`=0x1244, `link`=0x14. Then JALR `rs1`=0x2221, `imm`=0 → `pc`=0x2220.
- Branches: at `pc`=0x40 with `imm`=-8, BEQ with `zero`=1 → 0x38; BNE with `zero`=1 → 0x44; BLTU with `ltu`=1 → taken; BGE with `negative`=1 → not taken.
- Stall redirect: at `pc`=0x80 with `iready`=0, JAL `imm`=0x20 → `stalled`=1 and `pc` stays 0x80 for 3 cycles; raise `iready` → `pc`=0xA0, `stalled`=0.
- Misalign (IALIGN=32): JAL `imm`=0x6 → `fault`=1 and `pc` frozen for 4 cycles despite ops; pulse `fault_clr` → `pc`=TRAP_VEC, `fault`=0.
- Wrap/reset mid-HOLD: `pc`=0xFFFFFFFC with PC_SEQ → 0. Enter HOLD, then assert `RST` → `pc`=RESET_VEC and the pending target is never applied.
